// File: rtl/sha1_msg_sched.sv
// sha1_msg_sched
// Fetches one 16-word message block from a synchronous RAM and streams the
// 80-word SHA-1 message schedule, one word per cycle, with no gaps.
//
// State    | Meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; outputs hold, busy low
// S_LOAD   | issuing 16 RAM reads, emitting W[0..15] as data returns
// S_EXPAND | emitting W[16..79] from the 16-word window, no RAM traffic
// S_FIN    | stream finished; done pulses on leaving this state
module sha1_msg_sched #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int ROUNDS = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_out,
    output logic [6:0]        w_idx,
    output logic              busy,
    output logic              done
);

    localparam int WIN_N = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_FIN
    } state_t;

    state_t state_q;
    state_t state_d;

    // Reads still to issue; a down-counter so the last read is rd_left == 1.
    logic [4:0]        rd_left;
    // Read-valid pipe: rv1 marks ram_dout valid, rv2 marks dq valid.
    logic              rv1;
    logic              rv2;
    logic [DATA_W-1:0] dq;
    // Index of the next word to be emitted.
    logic [6:0]        idx_q;
    // win[15] is the newest word, win[0] is W[t-16].
    logic [DATA_W-1:0] win [WIN_N];

    logic              accept;
    logic              issue;
    logic              load_emit;
    logic              exp_emit;
    logic              emit;
    logic              finish;
    logic [DATA_W-1:0] w_mix;
    logic [DATA_W-1:0] w_new;
    logic [DATA_W-1:0] emit_word;

    // Schedule recurrence and emit/handshake qualifiers.
    always_comb begin
        w_mix     = win[13] ^ win[8] ^ win[2] ^ win[0];
        w_new     = {w_mix[DATA_W-2:0], w_mix[DATA_W-1]};
        accept    = (state_q == S_IDLE) && start;
        issue     = (state_q == S_LOAD) && (rd_left != 5'd0);
        load_emit = (state_q == S_LOAD) && rv2;
        exp_emit  = (state_q == S_EXPAND);
        emit      = load_emit || exp_emit;
        finish    = (state_q == S_FIN);
        emit_word = load_emit ? dq : w_new;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Switch as W[15] is emitted so W[16] follows with no bubble.
                if (load_emit && (idx_q == 7'(WIN_N - 1))) begin
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (idx_q == 7'(ROUNDS - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read address generation and read-valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_raddr <= '0;
            rd_left   <= '0;
            rv1       <= 1'b0;
            rv2       <= 1'b0;
            dq        <= '0;
        end else begin
            rv1 <= issue;
            rv2 <= rv1;
            dq  <= ram_dout;
            if (accept) begin
                ram_raddr <= base_addr;
                rd_left   <= 5'(WIN_N);
            end else if (issue) begin
                rd_left <= rd_left - 5'd1;
                // Hold on the last address once all 16 reads are out.
                if (rd_left != 5'd1) begin
                    ram_raddr <= ram_raddr + ADDR_W'(1);
                end
            end
        end
    end

    // Output stream, index counter and schedule window.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= 1'b0;
            w_out   <= '0;
            w_idx   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                win[i] <= '0;
            end
        end else begin
            w_valid <= emit;
            if (accept) begin
                idx_q <= '0;
            end else if (emit) begin
                w_out <= emit_word;
                w_idx <= idx_q;
                idx_q <= idx_q + 7'd1;
                for (int i = 0; i < WIN_N - 1; i++) begin
                    win[i] <= win[i+1];
                end
                win[WIN_N-1] <= emit_word;
            end
        end
    end

    // Block status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Scoreboard bench for sha1_msg_sched: stimulus pushes expected words and
// done times into queues, a negedge monitor pops and compares.
module tb_sha1_msg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  base_addr;
    logic [6:0]  ram_raddr;
    logic [31:0] ram_dout = '0;
    logic        w_valid;
    logic [31:0] w_out;
    logic [6:0]  w_idx;
    logic        busy;
    logic        done;

    sha1_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout),
        .w_valid   (w_valid),
        .w_out     (w_out),
        .w_idx     (w_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    always @(posedge clk) ram_dout <= mem[ram_raddr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  idx;
        logic [31:0] w;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned done_q[$];
    exp_t        e_mon;
    int unsigned d_mon;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] got_w [0:79];

    function automatic void chk(bit ok, string name, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endfunction

    // Expected stream: W[t] at edge e+3+t, done at edge e+83.
    task automatic push_block(input int unsigned e, input logic [6:0] base);
        logic [31:0] w [80];
        logic [31:0] x;
        exp_t        it;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) w[t] = mem[7'(base + t)];
            else begin
                x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
                w[t] = {x[30:0], x[31]};
            end
            it.cyc = e + 3 + t;
            it.idx = 7'(t);
            it.w   = w[t];
            exp_q.push_back(it);
        end
        done_q.push_back(e + 83);
    endtask

    // Monitor: compare every presented word and done pulse.
    always @(negedge clk) begin
        if (w_valid) begin
            if (w_idx < 7'd80) got_w[w_idx] = w_out;
            if (exp_q.size() == 0) chk(1'b0, "unexpected_w", {25'd0, w_idx, w_out}, 64'd0);
            else begin
                e_mon = exp_q.pop_front();
                chk(w_out == e_mon.w && w_idx == e_mon.idx && cyc == e_mon.cyc, "w_stream",
                    {cyc[24:0], w_idx, w_out}, {e_mon.cyc[24:0], e_mon.idx, e_mon.w});
            end
        end
        if (done) begin
            if (done_q.size() == 0) chk(1'b0, "unexpected_done", 64'(cyc), 64'd0);
            else begin
                d_mon = done_q.pop_front();
                chk(cyc == d_mon, "done_time", 64'(cyc), 64'(d_mon));
            end
        end
    end

    task automatic pulse_start(input logic [6:0] b, output int unsigned e);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        e         = cyc + 1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = ~b;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(seen, name, 64'(seen), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(w_valid == 1'b0, {name, "_w_valid"}, 64'(w_valid), 64'd0);
        chk(w_out == 32'd0, {name, "_w_out"}, 64'(w_out), 64'd0);
        chk(w_idx == 7'd0, {name, "_w_idx"}, 64'(w_idx), 64'd0);
        chk(busy == 1'b0, {name, "_busy"}, 64'(busy), 64'd0);
        chk(done == 1'b0, {name, "_done"}, 64'(done), 64'd0);
        chk(ram_raddr == 7'd0, {name, "_raddr"}, 64'(ram_raddr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e;
        int unsigned e2;
        bit          hit;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // "abc" block at base 0.
        mem[0]  = 32'h61626380;
        mem[15] = 32'h00000018;
        for (int k = 0; k < 16; k++) mem[16+k] = 32'hA5000000 | 32'(k * 3);
        pulse_start(7'd0, e);
        push_block(e, 7'd0);
        chk(busy == 1'b1, "busy_after_start", 64'(busy), 64'd1);
        wait_done("abc_done");
        chk(busy == 1'b0, "busy_at_done", 64'(busy), 64'd0);
        chk(w_valid == 1'b0, "valid_at_done", 64'(w_valid), 64'd0);
        chk(got_w[0] == 32'h61626380, "abc_w0", 64'(got_w[0]), 64'h61626380);
        chk(got_w[15] == 32'h00000018, "abc_w15", 64'(got_w[15]), 64'h00000018);
        chk(got_w[16] == 32'hC2C4C700, "abc_w16", 64'(got_w[16]), 64'hC2C4C700);
        chk(got_w[17] == 32'h00000000, "abc_w17", 64'(got_w[17]), 64'h0);
        chk(got_w[18] == 32'h00000030, "abc_w18", 64'(got_w[18]), 64'h30);
        chk(got_w[19] == 32'h85898E01, "abc_w19", 64'(got_w[19]), 64'h85898E01);

        // Back-to-back: starts while busy are ignored, then restart right after done.
        pulse_start(7'd0, e);
        push_block(e, 7'd0);
        repeat (3) @(negedge clk);
        start = 1'b1; base_addr = 7'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1; base_addr = 7'd90;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first_done");
        start     = 1'b1;
        base_addr = 7'd16;
        e2        = cyc + 1;
        push_block(e2, 7'd16);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second_done");

        // Address wrap from base 120.
        for (int k = 0; k < 16; k++) mem[(120 + k) % 128] = 32'(k + 1);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 7'd120;
        e         = cyc + 1;
        push_block(e, 7'd120);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            chk(ram_raddr == 7'((120 + k) % 128), "wrap_raddr", 64'(ram_raddr), 64'((120 + k) % 128));
        end
        repeat (4) @(negedge clk);
        chk(ram_raddr == 7'd7, "wrap_raddr_hold", 64'(ram_raddr), 64'd7);
        wait_done("wrap_done");
        chk(got_w[0] == 32'd1, "wrap_w0", 64'(got_w[0]), 64'd1);
        chk(got_w[15] == 32'd16, "wrap_w15", 64'(got_w[15]), 64'd16);

        // Reset in the middle of expansion.
        for (int k = 0; k < 16; k++) mem[64+k] = 32'h01234567 * 32'(k + 1);
        pulse_start(7'd64, e);
        push_block(e, 7'd64);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (w_valid && w_idx == 7'd40) hit = 1'b1;
        end
        chk(hit, "reach_idx40", 64'(hit), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        pulse_start(7'd64, e);
        push_block(e, 7'd64);
        wait_done("post_reset_done");

        // start held high: one block per IDLE visit.
        for (int k = 0; k < 16; k++) mem[32+k] = 32'hDEAD0000 ^ 32'(k << 4);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 7'd32;
        e         = cyc + 1;
        push_block(e, 7'd32);
        push_block(e + 84, 7'd32);
        push_block(e + 168, 7'd32);
        for (int i = 0; i < 400 && cyc < e + 168; i++) @(negedge clk);
        start = 1'b0;
        wait_done("held_done");
        repeat (6) @(negedge clk);
        chk(exp_q.size() == 0, "exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk(done_q.size() == 0, "done_q_drained", 64'(done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
